game_timer: RTL and testbench

- Writer end of the finish-time path: counts elapsed play time in whole seconds and freezes it when the run ends.
- Drives the 32-bit time value that is written to register 12, plus the per-digit BCD values and the level finish_en consumed by the finish-screen display.
- Lives in the game-logic clock domain (pixel clock); all outputs are registered.

---
 rtl/game_timer_pkg.sv | 14 +
 rtl/game_timer_bcd_counter_2dig.sv | 34 +++
 rtl/game_timer.sv | 116 +++++++++++
 tb/tb_game_timer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// rtl/game_timer_pkg.sv - shared types and constants for the finish-time counter
package game_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/game_timer_bcd_counter_2dig.sv
// rtl/game_timer_bcd_counter_2dig.sv - two-digit BCD up-counter with priority clear
module bcd_counter_2dig
    import game_timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               carry
);

    // Flags the increment that would roll 99 back to 00.
    assign carry = inc && !clr && (ones == BCD_MAX_DIGIT) && (tens == BCD_MAX_DIGIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (ones == BCD_MAX_DIGIT) begin
                ones <= '0;
                tens <= (tens == BCD_MAX_DIGIT) ? '0 : tens + 1'b1;
            end else begin
                ones <= ones + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_timer.sv
// rtl/game_timer.sv - elapsed-seconds timer that freezes on finish or timeout
module game_timer
    import game_timer_pkg::*;
#(
    parameter int CLK_HZ      = 25_000_000,
    parameter int MAX_SECONDS = 99
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               finish,
    output logic [31:0]        time_out,
    output logic [DIGIT_W-1:0] digit_10s,
    output logic [DIGIT_W-1:0] digit_1s,
    output logic               running,
    output logic               finish_en,
    output logic               done_pulse,
    output logic               timeout
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [6:0]    SECS_LAST  = 7'(MAX_SECONDS - 1);

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] presc;
    logic [6:0]    secs;
    logic          tick;
    logic          clr;
    logic          hit_max;
    logic          bcd_carry;

    assign tick     = (state == RUN) && !pause && (presc == PRESC_LAST);
    assign time_out = {25'd0, secs};

    always_comb begin
        next_state = state;
        clr        = 1'b0;
        hit_max    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    clr        = 1'b1;
                end
            end
            RUN: begin
                // A tick landing on the last second ends the run on the same edge.
                hit_max = tick && ((secs == SECS_LAST) || bcd_carry);
                if (finish || hit_max) begin
                    next_state = DONE;
                end else if (pause) begin
                    next_state = PAUSE;
                end
            end
            PAUSE: begin
                if (finish) begin
                    next_state = DONE;
                end else if (!pause) begin
                    next_state = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    next_state = RUN;
                    clr        = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            secs       <= '0;
            running    <= 1'b0;
            finish_en  <= 1'b0;
            done_pulse <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= next_state;
            running    <= (next_state == RUN);
            finish_en  <= (next_state == DONE);
            done_pulse <= (next_state == DONE) && (state != DONE);
            if (clr) begin
                timeout <= 1'b0;
            end else if (hit_max) begin
                timeout <= 1'b1;
            end
            if (clr) begin
                presc <= '0;
                secs  <= '0;
            end else if ((state == RUN) && !pause) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    secs <= secs + 1'b1;
                end
            end
        end
    end

    bcd_counter_2dig u_bcd (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (tick),
        .tens  (digit_10s),
        .ones  (digit_1s),
        .carry (bcd_carry)
    );

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - directed vector bench for game_timer with CLK_HZ=4
module tb_game_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        finish = 1'b0;
    logic [31:0] time_out;
    logic [3:0]  digit_10s;
    logic [3:0]  digit_1s;
    logic        running;
    logic        finish_en;
    logic        done_pulse;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    game_timer #(.CLK_HZ(4), .MAX_SECONDS(99)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .finish     (finish),
        .time_out   (time_out),
        .digit_10s  (digit_10s),
        .digit_1s   (digit_1s),
        .running    (running),
        .finish_en  (finish_en),
        .done_pulse (done_pulse),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        pa;
        logic        fi;
        int          n;
        logic [31:0] t;
        logic [3:0]  d10;
        logic [3:0]  d1;
        logic        run;
        logic        fe;
        logic        dp;
        logic        to;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic st, input logic pa, input logic fi, input int n,
                                input int t, input int d10, input int d1,
                                input logic run, input logic fe, input logic dp, input logic to);
        vec_t v;
        v.st = st; v.pa = pa; v.fi = fi; v.n = n;
        v.t = 32'(t); v.d10 = 4'(d10); v.d1 = 4'(d1);
        v.run = run; v.fe = fe; v.dp = dp; v.to = to;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int t, input int d10, input int d1,
                             input logic run, input logic fe, input logic dp, input logic to);
        chk({tag, ".time_out"}, time_out, 32'(t));
        chk({tag, ".digit_10s"}, {28'd0, digit_10s}, 32'(d10));
        chk({tag, ".digit_1s"}, {28'd0, digit_1s}, 32'(d1));
        chk({tag, ".running"}, {31'd0, running}, {31'd0, run});
        chk({tag, ".finish_en"}, {31'd0, finish_en}, {31'd0, fe});
        chk({tag, ".done_pulse"}, {31'd0, done_pulse}, {31'd0, dp});
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, to});
    endtask

    // Hold the given inputs for n rising edges, then sample 1 time unit after the last edge.
    task automatic apply(input logic s, input logic p, input logic f, input int n);
        start = s; pause = p; finish = f;
        repeat (n) @(posedge clk);
        #1;
        start = 1'b0; pause = 1'b0; finish = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 0, 1,   0, 0, 0, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 40, 10, 1, 0, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 3,  10, 1, 0, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 1,  11, 1, 1, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 2,  11, 1, 1, 1, 0, 0, 0);
        vecs[5]  = mk(0, 1, 0, 20, 11, 1, 1, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 1,  11, 1, 1, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 1,  11, 1, 1, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 1,  12, 1, 2, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 1, 1,  12, 1, 2, 0, 1, 1, 0);
        vecs[10] = mk(0, 0, 0, 1,  12, 1, 2, 0, 1, 0, 0);
        vecs[11] = mk(0, 1, 1, 1,  12, 1, 2, 0, 1, 0, 0);
        vecs[12] = mk(0, 0, 0, 10, 12, 1, 2, 0, 1, 0, 0);
        vecs[13] = mk(1, 0, 0, 1,   0, 0, 0, 1, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 8,   2, 0, 2, 1, 0, 0, 0);
        vecs[15] = mk(1, 0, 0, 1,   2, 0, 2, 1, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 3,   3, 0, 3, 1, 0, 0, 0);
        vecs[17] = mk(1, 0, 1, 1,   3, 0, 3, 0, 1, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        apply(0, 1, 1, 1);
        check_all("idle_ignore", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].st, vecs[i].pa, vecs[i].fi, vecs[i].n);
            check_all($sformatf("vec%0d", i), int'(vecs[i].t), int'(vecs[i].d10), int'(vecs[i].d1),
                      vecs[i].run, vecs[i].fe, vecs[i].dp, vecs[i].to);
        end

        // Pause after 3 s: prescaler resumes from 0 and needs four RUN edges to tick.
        do_reset();
        apply(1, 0, 0, 1);
        apply(0, 0, 0, 12);
        check_all("p3_before", 3, 0, 3, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            apply(0, 1, 0, 1);
            chk($sformatf("p3_hold%0d.time_out", i), time_out, 32'd3);
        end
        apply(0, 0, 0, 1);
        check_all("p3_resume", 3, 0, 3, 1, 0, 0, 0);
        apply(0, 0, 0, 3);
        check_all("p3_pre_tick", 3, 0, 3, 1, 0, 0, 0);
        apply(0, 0, 0, 1);
        check_all("p3_tick", 4, 0, 4, 1, 0, 0, 0);

        // Finish exactly on the 5th tick edge includes that tick.
        do_reset();
        apply(1, 0, 0, 1);
        apply(0, 0, 0, 19);
        check_all("f5_pre", 4, 0, 4, 1, 0, 0, 0);
        apply(0, 0, 1, 1);
        check_all("f5_done", 5, 0, 5, 0, 1, 1, 0);
        apply(0, 0, 0, 1);
        check_all("f5_hold", 5, 0, 5, 0, 1, 0, 0);
        apply(0, 1, 1, 3);
        check_all("f5_ignore", 5, 0, 5, 0, 1, 0, 0);

        // Timeout at 99 s, no wrap, then restart.
        do_reset();
        apply(1, 0, 0, 1);
        apply(0, 0, 0, 395);
        check_all("to_98", 98, 9, 8, 1, 0, 0, 0);
        apply(0, 0, 0, 1);
        check_all("to_99", 99, 9, 9, 0, 1, 1, 1);
        apply(0, 0, 0, 10);
        check_all("to_hold", 99, 9, 9, 0, 1, 0, 1);
        apply(1, 0, 0, 1);
        check_all("to_restart", 0, 0, 0, 1, 0, 0, 0);

        // Reset mid-RUN at 7 s and mid-DONE.
        do_reset();
        apply(1, 0, 0, 1);
        apply(0, 0, 0, 28);
        check_all("r_7s", 7, 0, 7, 1, 0, 0, 0);
        reset = 1'b1;
        finish = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        finish = 1'b0;
        check_all("r_run", 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 1);
        check_all("r_idle_fin", 0, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 1);
        apply(0, 0, 0, 4);
        apply(0, 0, 1, 1);
        check_all("r_done", 1, 0, 1, 0, 1, 1, 0);
        do_reset();
        check_all("r_after_done", 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
